// File: rtl/itoa_tx.sv
// rtl/itoa_tx.sv - 16-bit unsigned to ASCII decimal byte transmitter (optional terminator: ITOA_TERM_EN)
module itoa_tx #(
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  // TERM gets the highest code so the default build simply never reaches it.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_EMIT = 3'd2,
    S_FIN  = 3'd3
`ifdef ITOA_TERM_EN
    ,
    S_TERM = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_rem;
  logic [2:0]  r_idx;
  logic [3:0]  r_cnt;
  logic        r_started;
  logic [7:0]  r_char;

  logic [15:0] w_pow;
  logic        w_ge;
  logic        w_emit_digit;
  logic        w_hs;
  logic        w_accept;

`ifndef ITOA_TERM_EN
  // The terminator byte only exists in the ITOA_TERM_EN build.
  logic [7:0]  w_unused_term;
  assign w_unused_term = TERM_CHAR;
`endif

  // Power of ten selected by the current digit position.
  always_comb begin
    case (r_idx)
      3'd4:    w_pow = 16'd10000;
      3'd3:    w_pow = 16'd1000;
      3'd2:    w_pow = 16'd100;
      3'd1:    w_pow = 16'd10;
      default: w_pow = 16'd1;
    endcase
  end

  // A digit is ready to emit once no more subtraction fits; leading zeros are skipped
  // except in the units position, so the value 0 still produces a single '0'.
  assign w_ge         = (r_rem >= w_pow);
  assign w_emit_digit = (r_cnt != 4'd0) || r_started || (r_idx == 3'd0);
  assign w_hs         = out_valid && out_ready;
  assign w_accept     = start && ((r_state == S_IDLE) || (r_state == S_FIN));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CONV;
      end
      S_CONV: begin
        if (!w_ge && w_emit_digit) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (w_hs) begin
          if (r_idx != 3'd0) begin
            w_next = S_CONV;
          end else begin
`ifdef ITOA_TERM_EN
            w_next = S_TERM;
`else
            w_next = S_FIN;
`endif
          end
        end
      end
`ifdef ITOA_TERM_EN
      S_TERM: begin
        if (w_hs) w_next = S_FIN;
      end
`endif
      S_FIN: begin
        // A start arriving during the done pulse is taken like one in IDLE.
        w_next = start ? S_CONV : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: repeated subtraction of the current power, one step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= 16'd0;
      r_idx     <= 3'd0;
      r_cnt     <= 4'd0;
      r_started <= 1'b0;
      r_char    <= 8'h00;
    end else begin
      if (w_accept) begin
        r_rem     <= value;
        r_idx     <= 3'd4;
        r_cnt     <= 4'd0;
        r_started <= 1'b0;
      end else if (r_state == S_CONV) begin
        if (w_ge) begin
          r_rem <= r_rem - w_pow;
          r_cnt <= r_cnt + 4'd1;
        end else if (w_emit_digit) begin
          r_char    <= 8'h30 + {4'b0000, r_cnt};
          r_started <= 1'b1;
        end else begin
          r_idx <= r_idx - 3'd1;
          r_cnt <= 4'd0;
        end
      end else if ((r_state == S_EMIT) && w_hs && (r_idx != 3'd0)) begin
        r_idx <= r_idx - 3'd1;
        r_cnt <= 4'd0;
      end
    end
  end

  // Outputs decoded from state only, so out_ready never reaches out_valid/out_char.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    out_char  = r_char;
    case (r_state)
      S_CONV: begin
        busy = 1'b1;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
`ifdef ITOA_TERM_EN
      S_TERM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_char  = TERM_CHAR;
      end
`endif
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_itoa_tx.sv
// tb/tb_itoa_tx.sv - self-checking bench for itoa_tx against a decimal-string model
`timescale 1ns/1ps
module tb_itoa_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] value = 16'd0;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        done;

  int n_checks = 0;
  int n_errs = 0;

  logic [7:0] exp_q[$];

  itoa_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal text of v, most significant digit first, plus optional terminator.
  task automatic build_expected(input int v);
    int x;
    exp_q.delete();
    x = v;
    do begin
      exp_q.push_front(8'(48 + (x % 10)));
      x = x / 10;
    end while (x != 0);
`ifdef ITOA_TERM_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Negedge index (after the start negedge) at which done is seen with out_ready held high.
  function automatic int exp_done_cycle(input int v);
    int p[5] = '{10000, 1000, 100, 10, 1};
    int t = 0;
    bit st = 1'b0;
    int d;
    for (int k = 0; k < 5; k++) begin
      d = (v / p[k]) % 10;
      if (d == 0 && !st && k != 4) begin
        t += 1;
      end else begin
        st = 1'b1;
        t += d + 2;
      end
    end
`ifdef ITOA_TERM_EN
    t += 1;
`endif
    return t + 1;
  endfunction

  task automatic do_conv(input logic [15:0] v, input int pct, input int mid, input bit pre,
                         input bit chain, input logic [15:0] chain_v, input string tag);
    logic [7:0] got[$];
    bit         pv;
    bit         pr;
    logic [7:0] pc;
    int         vcyc;
    bit         seen;
    build_expected(int'(v));
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
      value = v;
    end
    pv = 1'b0; pr = 1'b0; pc = 8'h00; vcyc = 0; seen = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        check({tag, ":busy_rise"}, 32'(busy), 32'd1);
        check({tag, ":done_low"}, 32'(done), 32'd0);
      end
      if (mid != 0 && i == mid) begin
        start = 1'b1;
        value = 16'd99;
      end
      if (pv && !pr) begin
        check({tag, ":stall_valid"}, 32'(out_valid), 32'd1);
        check({tag, ":stall_char"}, 32'(out_char), 32'(pc));
      end
      if (done) begin
        seen = 1'b1;
        check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ":valid_at_done"}, 32'(out_valid), 32'd0);
        if (pct >= 100) begin
          check({tag, ":latency"}, 32'(i), 32'(exp_done_cycle(int'(v))));
          check({tag, ":valid_cycles"}, 32'(vcyc), 32'(exp_q.size()));
        end
        if (chain) begin
          start = 1'b1;
          value = chain_v;
        end
        break;
      end
      out_ready = (pct >= 100) ? 1'b1 : 1'($urandom_range(99) < pct);
      if (out_valid) vcyc++;
      if (out_valid && out_ready) got.push_back(out_char);
      pv = out_valid;
      pr = out_ready;
      pc = out_char;
    end
    check({tag, ":done_seen"}, 32'(seen), 32'd1);
    check({tag, ":byte_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("%s:byte%0d", tag, k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF,
            32'(exp_q[k]));
    end
    if (!chain && seen) begin
      @(negedge clk);
      check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
      check({tag, ":busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    bit found;
    logic [15:0] rv;
    int rp;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:valid", 32'(out_valid), 32'd0);
    check("rst:char", 32'(out_char), 32'h00);
    check("rst:done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle:busy", 32'(busy), 32'd0);

    // Directed values
    do_conv(16'd0,     100, 0, 1'b0, 1'b0, 16'd0, "v0");
    do_conv(16'd65535, 100, 0, 1'b0, 1'b0, 16'd0, "v65535");
    do_conv(16'd1200,  100, 0, 1'b0, 1'b0, 16'd0, "v1200");
    do_conv(16'd7,     100, 0, 1'b0, 1'b0, 16'd0, "v7");
    do_conv(16'd305,    50, 0, 1'b0, 1'b0, 16'd0, "v305_stall");

    // Start ignored while busy, then start during the done cycle
    do_conv(16'd42,    100, 3, 1'b0, 1'b1, 16'd9, "v42_midstart");
    do_conv(16'd9,     100, 0, 1'b1, 1'b0, 16'd0, "v9_chained");

    // Randomized values and backpressure
    for (int n = 0; n < 16; n++) begin
      rv = 16'($urandom);
      if ($urandom_range(1) == 0) rv = 16'($urandom_range(999));
      case ($urandom_range(2))
        0:       rp = 100;
        1:       rp = 70;
        default: rp = 30;
      endcase
      do_conv(rv, rp, 0, 1'b0, 1'b0, 16'd0, $sformatf("rnd%0d_%0d", n, rv));
    end

    // Asynchronous reset while a byte is pending
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    value = 16'd65535;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("arst:valid_before", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst:valid", 32'(out_valid), 32'd0);
    check("arst:busy", 32'(busy), 32'd0);
    check("arst:done", 32'(done), 32'd0);
    check("arst:char", 32'(out_char), 32'h00);
    @(negedge clk);
    check("arst:done_held", 32'(done), 32'd0);
    rst_n = 1'b1;
    do_conv(16'd10, 100, 0, 1'b0, 1'b0, 16'd0, "v10_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
